// File: rtl/cc_pkg.sv
// Shared widths and request/line typedefs for the cache tag-lookup stage.
package cc_pkg;
  localparam int TAG_W  = 18;
  localparam int IDX_W  = 8;
  localparam int OFF_W  = 6;
  localparam int LINE_W = TAG_W + IDX_W;

  typedef logic [LINE_W-1:0] line_addr_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
  } req_t;

  function automatic line_addr_t line_of(input req_t r);
    return {r.tag, r.index};
  endfunction
endpackage

// File: rtl/cc_valid_array.sv
// Per-set valid flops: set-only write port, asynchronous read at one index.
module cc_valid_array
  import cc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set_en,
  input  logic [IDX_W-1:0] i_set_idx,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_vld
);
  localparam int DEPTH = 2 ** IDX_W;

  logic [DEPTH-1:0] r_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else if (i_set_en) begin
      r_vld[i_set_idx] <= 1'b1;
    end
  end

  assign o_rd_vld = r_vld[i_rd_idx];
endmodule

// File: rtl/cc_tag_lookup.sv
// Direct-mapped tag lookup: SRAM read, compare with fill forwarding, hit/miss FIFO pushes.
// Optional CC_LOOKUP_STATS_EN adds saturating hit_cnt_o / miss_cnt_o counters.
module cc_tag_lookup
  import cc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             hs_pulse_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [IDX_W-1:0] index_i,
  input  logic [OFF_W-1:0] offset_i,
  output logic             tag_sram_en_o,
  output logic             tag_sram_we_o,
  output logic [IDX_W-1:0] tag_sram_addr_o,
  output logic [TAG_W-1:0] tag_sram_wdata_o,
  input  logic [TAG_W-1:0] tag_sram_rdata_i,
  input  logic             fill_valid_i,
  input  logic [IDX_W-1:0] fill_index_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  output logic             hit_flag_fifo_wren_o,
  output logic             hit_flag_fifo_wdata_o,
  output logic             miss_addr_fifo_wren_o,
  output logic [31:0]      miss_addr_fifo_wdata_o,
  output logic             miss_req_fifo_wren_o,
  output logic [31:0]      miss_req_fifo_wdata_o
`ifdef CC_LOOKUP_STATS_EN
  ,
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o
`endif
);
  logic             r_s1_vld;
  req_t             r_s1_req;
  logic             r_buf_vld;
  logic [IDX_W-1:0] r_buf_idx;
  logic [TAG_W-1:0] r_buf_tag;
  logic             r_mp_vld;
  line_addr_t       r_mp_line;

  logic             w_buf_load;
  logic             w_rd_vld;
  logic             w_cmp_vld;
  logic [TAG_W-1:0] w_cmp_tag;
  logic             w_hit;
  logic             w_miss;
  logic             w_primary;
  line_addr_t       w_s1_line;

  cc_valid_array u_valid (
    .clk      (clk),
    .rst      (rst),
    .i_set_en (fill_valid_i),
    .i_set_idx(fill_index_i),
    .i_rd_idx (r_s1_req.index),
    .o_rd_vld (w_rd_vld)
  );

  // Port priority: request read, then parked fill, then a direct fill write.
  always_comb begin
    tag_sram_en_o    = 1'b0;
    tag_sram_we_o    = 1'b0;
    tag_sram_addr_o  = '0;
    tag_sram_wdata_o = '0;
    w_buf_load       = 1'b0;
    if (hs_pulse_i) begin
      tag_sram_en_o   = 1'b1;
      tag_sram_addr_o = index_i;
      w_buf_load      = fill_valid_i;
    end else if (r_buf_vld) begin
      tag_sram_en_o    = 1'b1;
      tag_sram_we_o    = 1'b1;
      tag_sram_addr_o  = r_buf_idx;
      tag_sram_wdata_o = r_buf_tag;
      w_buf_load       = fill_valid_i;
    end else if (fill_valid_i) begin
      tag_sram_en_o    = 1'b1;
      tag_sram_we_o    = 1'b1;
      tag_sram_addr_o  = fill_index_i;
      tag_sram_wdata_o = fill_tag_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_req  <= '0;
      r_buf_vld <= 1'b0;
      r_buf_idx <= '0;
      r_buf_tag <= '0;
    end else begin
      r_s1_vld <= hs_pulse_i;
      if (hs_pulse_i) begin
        r_s1_req <= '{tag: tag_i, index: index_i, offset: offset_i};
      end
      if (w_buf_load) begin
        r_buf_vld <= 1'b1;
        r_buf_idx <= fill_index_i;
        r_buf_tag <= fill_tag_i;
      end else if (!hs_pulse_i) begin
        r_buf_vld <= 1'b0;
      end
    end
  end

  // Same-cycle fill is newer than the parked one, so it takes precedence.
  always_comb begin
    w_cmp_tag = tag_sram_rdata_i;
    w_cmp_vld = w_rd_vld;
    if (r_buf_vld && (r_buf_idx == r_s1_req.index)) begin
      w_cmp_tag = r_buf_tag;
    end
    if (fill_valid_i && (fill_index_i == r_s1_req.index)) begin
      w_cmp_tag = fill_tag_i;
      w_cmp_vld = 1'b1;
    end
  end

  assign w_s1_line = line_of(r_s1_req);
  assign w_hit     = w_cmp_vld && (w_cmp_tag == r_s1_req.tag);
  assign w_miss    = r_s1_vld && !w_hit;
  assign w_primary = w_miss && !(r_mp_vld && (r_mp_line == w_s1_line));

  assign hit_flag_fifo_wren_o   = r_s1_vld;
  assign hit_flag_fifo_wdata_o  = r_s1_vld && w_hit;
  assign miss_addr_fifo_wren_o  = w_miss;
  assign miss_addr_fifo_wdata_o = w_miss ? 32'(r_s1_req) : 32'd0;
  assign miss_req_fifo_wren_o   = w_primary;
  assign miss_req_fifo_wdata_o  = w_primary ? {w_s1_line, {OFF_W{1'b0}}} : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mp_vld  <= 1'b0;
      r_mp_line <= '0;
    end else if (w_primary) begin
      r_mp_vld  <= 1'b1;
      r_mp_line <= w_s1_line;
    end else if (fill_valid_i && r_mp_vld && (fill_index_i == r_mp_line[IDX_W-1:0])) begin
      r_mp_vld <= 1'b0;
    end
  end

`ifdef CC_LOOKUP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (r_s1_vld) begin
      if (w_hit && (hit_cnt_o != 32'hFFFF_FFFF)) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (!w_hit && (miss_cnt_o != 32'hFFFF_FFFF)) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

  // The miss handler spaces fills so a parked fill never meets a new fill plus a read.
  a_fill_collision: assert property (@(posedge clk) disable iff (rst)
    !(r_buf_vld && fill_valid_i && hs_pulse_i));
endmodule
